// File: rtl/nemu_dbg_pkg.sv
// Shared definitions for the NEMU debug capture bus: tag values, sequencer
// states and the helper that recognises a tag the sink understands.
package nemu_dbg_pkg;

    localparam int DBG_TAG_MSB = 29;
    localparam int DBG_TAG_W   = 8;

    localparam logic [DBG_TAG_W-1:0] TAG_CNT = 8'hA0;
    localparam logic [DBG_TAG_W-1:0] TAG_EIP = 8'hA1;
    localparam logic [DBG_TAG_W-1:0] TAG_BIN = 8'hA2;
    localparam logic [DBG_TAG_W-1:0] TAG_STR = 8'hA3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CNT  = 3'd1,
        ST_EIP  = 3'd2,
        ST_BIN  = 3'd3,
        ST_STR  = 3'd4
    } seq_state_e;

    function automatic logic is_dbg_tag(input logic [DBG_TAG_W-1:0] tag);
        return (tag == TAG_CNT) || (tag == TAG_EIP) || (tag == TAG_BIN) || (tag == TAG_STR);
    endfunction

endpackage

// File: rtl/nemu_trace_sequencer_if.sv
// Request/grant handshakes of the two requesters plus the debug capture bus
// the sequencer drives. The sequencer is the slave side.
interface nemu_trace_sequencer_if #(
    parameter int BIN_BYTES = 10,
    parameter int STR_BYTES = 32
);
    logic                   cpu_valid;
    logic [29:0]            cpu_addr;
    logic [31:0]            cpu_data;
    logic                   cpu_ready;
    logic                   trc_valid;
    logic [31:0]            trc_counter;
    logic [31:0]            trc_eip;
    logic [8*BIN_BYTES-1:0] trc_bin;
    logic [8*STR_BYTES-1:0] trc_str;
    logic [5:0]             trc_str_len;
    logic                   trc_ready;
    logic [29:0]            dbg_addr;
    logic [31:0]            dbg_data;
    logic                   dbg_we;
    logic                   busy;
    logic                   drop;

    modport master (
        output cpu_valid, cpu_addr, cpu_data,
        output trc_valid, trc_counter, trc_eip, trc_bin, trc_str, trc_str_len,
        input  cpu_ready, trc_ready, dbg_addr, dbg_data, dbg_we, busy, drop
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_data,
        input  trc_valid, trc_counter, trc_eip, trc_bin, trc_str, trc_str_len,
        output cpu_ready, trc_ready, dbg_addr, dbg_data, dbg_we, busy, drop
    );

endinterface

// File: rtl/nemu_rr_arb2.sv
// Two-way round-robin arbiter between CPU stores and trace records; hold_i
// blocks all grants while a record burst owns the bus.
module nemu_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic hold_i,
    input  logic req_cpu_i,
    input  logic req_trc_i,
    output logic gnt_cpu_o,
    output logic gnt_trc_o
);

    logic last_trc_q;
    logic last_trc_d;

    // Grant selection: a lone request wins, a tie goes against the last winner
    always_comb begin
        gnt_cpu_o = 1'b0;
        gnt_trc_o = 1'b0;
        if (!rst_n || hold_i) begin
            gnt_cpu_o = 1'b0;
            gnt_trc_o = 1'b0;
        end else if (req_cpu_i && req_trc_i) begin
            gnt_cpu_o = last_trc_q;
            gnt_trc_o = !last_trc_q;
        end else begin
            gnt_cpu_o = req_cpu_i;
            gnt_trc_o = req_trc_i;
        end
    end

    // Remember who won the latest grant
    always_comb begin
        last_trc_d = last_trc_q;
        if (gnt_cpu_o || gnt_trc_o) begin
            last_trc_d = gnt_trc_o;
        end else begin
            last_trc_d = last_trc_q;
        end
    end

    // Round-robin history register; the trace side counts as last winner after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_trc_q <= 1'b1;
        end else begin
            last_trc_q <= last_trc_d;
        end
    end

endmodule

// File: rtl/nemu_trace_sequencer.sv
// Arbitrates CPU debug stores against trace records and serialises each record
// into the tagged A0/A1/A2/A3 write burst; parks the bus on A1/last-eip when idle.
module nemu_trace_sequencer
    import nemu_dbg_pkg::*;
#(
    parameter int         BIN_BYTES = 10,
    parameter int         STR_BYTES = 32,
    parameter logic [7:0] PARK_TAG  = 8'hA1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nemu_trace_sequencer_if.slave  bus
);

    localparam logic [5:0] BIN_LAST = 6'(BIN_BYTES - 1);
    localparam logic [5:0] STR_MAX  = 6'(STR_BYTES);
    localparam int         BIN_OW   = $clog2(8 * BIN_BYTES);
    localparam int         STR_OW   = $clog2(8 * STR_BYTES);

    seq_state_e             state_q, state_d;
    logic [5:0]             idx_q, idx_d;
    logic [5:0]             len_q, len_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            eip_q, eip_d;
    logic [31:0]            shadow_q, shadow_d;
    logic [8*BIN_BYTES-1:0] bin_q, bin_d;
    logic [8*STR_BYTES-1:0] str_q, str_d;
    logic [29:0]            addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic                   we_q, we_d;
    logic                   busy_q, busy_d;
    logic                   drop_q, drop_d;

    logic                   accept_s;
    logic                   gnt_cpu_s;
    logic                   gnt_trc_s;
    logic                   cpu_tag_ok_s;
    logic [BIN_OW-1:0]      bin_off_s;
    logic [STR_OW-1:0]      str_off_s;

    assign cpu_tag_ok_s = is_dbg_tag(bus.cpu_addr[DBG_TAG_MSB -: DBG_TAG_W]);

    // Accept points: idle, or the cycle that shows the last byte of a burst
    always_comb begin
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: accept_s = 1'b1;
            ST_BIN:  accept_s = (idx_q == BIN_LAST) && (len_q == 6'd0);
            ST_STR:  accept_s = (idx_q == (len_q - 6'd1));
            default: accept_s = 1'b0;
        endcase
    end

    nemu_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold_i    (!accept_s),
        .req_cpu_i (bus.cpu_valid),
        .req_trc_i (bus.trc_valid),
        .gnt_cpu_o (gnt_cpu_s),
        .gnt_trc_o (gnt_trc_s)
    );

    assign bus.cpu_ready = gnt_cpu_s;
    assign bus.trc_ready = gnt_trc_s;

    // Next state; state and idx always describe the beat currently on the bus
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_trc_s) state_d = ST_CNT;
                else           state_d = ST_IDLE;
            end
            ST_CNT:  state_d = ST_EIP;
            ST_EIP: begin
                state_d = ST_BIN;
                idx_d   = 6'd0;
            end
            ST_BIN: begin
                if (idx_q != BIN_LAST) begin
                    idx_d = idx_q + 6'd1;
                end else if (len_q != 6'd0) begin
                    state_d = ST_STR;
                    idx_d   = 6'd0;
                end else if (gnt_trc_s) begin
                    state_d = ST_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STR: begin
                if (!accept_s)      idx_d   = idx_q + 6'd1;
                else if (gnt_trc_s) state_d = ST_CNT;
                else                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Record capture on grant; the string length is clamped here once
    always_comb begin
        cnt_d = cnt_q;
        eip_d = eip_q;
        bin_d = bin_q;
        str_d = str_q;
        len_d = len_q;
        if (gnt_trc_s) begin
            cnt_d = bus.trc_counter;
            eip_d = bus.trc_eip;
            bin_d = bus.trc_bin;
            str_d = bus.trc_str;
            len_d = (bus.trc_str_len > STR_MAX) ? STR_MAX : bus.trc_str_len;
        end else begin
            len_d = len_q;
        end
    end

    // Output comb: the beat to register for the next cycle, park by default
    always_comb begin
        bin_off_s = BIN_OW'({idx_d, 3'b000});
        str_off_s = STR_OW'({idx_d, 3'b000});
        addr_d    = {PARK_TAG, 22'd0};
        data_d    = shadow_q;
        we_d      = 1'b0;
        drop_d    = 1'b0;
        shadow_d  = shadow_q;
        busy_d    = (state_d != ST_IDLE);
        case (state_d)
            ST_CNT: begin
                addr_d = {TAG_CNT, 22'd0};
                data_d = cnt_d;
                we_d   = 1'b1;
            end
            ST_EIP: begin
                addr_d   = {TAG_EIP, 22'd0};
                data_d   = eip_d;
                we_d     = 1'b1;
                shadow_d = eip_d;
            end
            ST_BIN: begin
                addr_d = {TAG_BIN, 22'd0};
                data_d = {24'd0, bin_d[bin_off_s +: 8]};
                we_d   = 1'b1;
            end
            ST_STR: begin
                addr_d = {TAG_STR, 22'd0};
                data_d = {24'd0, str_d[str_off_s +: 8]};
                we_d   = 1'b1;
            end
            ST_IDLE: begin
                if (gnt_cpu_s && cpu_tag_ok_s) begin
                    addr_d = bus.cpu_addr;
                    data_d = bus.cpu_data;
                    we_d   = 1'b1;
                    if (bus.cpu_addr[DBG_TAG_MSB -: DBG_TAG_W] == TAG_EIP) shadow_d = bus.cpu_data;
                    else                                                   shadow_d = shadow_q;
                end else begin
                    drop_d = gnt_cpu_s;
                end
            end
            default: begin
                addr_d = {PARK_TAG, 22'd0};
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Record latch and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= 6'd0;
            cnt_q    <= 32'd0;
            eip_q    <= 32'd0;
            bin_q    <= '0;
            str_q    <= '0;
            shadow_q <= 32'd0;
            addr_q   <= {PARK_TAG, 22'd0};
            data_q   <= 32'd0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            eip_q    <= eip_d;
            bin_q    <= bin_d;
            str_q    <= str_d;
            shadow_q <= shadow_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.dbg_addr = addr_q;
    assign bus.dbg_data = data_q;
    assign bus.dbg_we   = we_q;
    assign bus.busy     = busy_q;
    assign bus.drop     = drop_q;

endmodule

// File: tb/tb_nemu_trace_sequencer.sv
// Bench for nemu_trace_sequencer: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-of-expected-beats reference model.
module tb_nemu_trace_sequencer;

    localparam int BIN_BYTES = 10;
    localparam int STR_BYTES = 32;
    localparam logic [7:0] T_CNT = 8'hA0;
    localparam logic [7:0] T_EIP = 8'hA1;
    localparam logic [7:0] T_BIN = 8'hA2;
    localparam logic [7:0] T_STR = 8'hA3;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic        we;
        logic        busy;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    nemu_trace_sequencer_if #(.BIN_BYTES(BIN_BYTES), .STR_BYTES(STR_BYTES)) bus ();

    nemu_trace_sequencer #(.BIN_BYTES(BIN_BYTES), .STR_BYTES(STR_BYTES), .PARK_TAG(8'hA1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    beat_t cur;
    logic [31:0] shadow;
    logic  rr_trc;
    logic  exp_drop;
    logic  g_cpu;
    logic  g_trc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic beat_t park_beat();
        return {T_EIP, 22'd0, shadow, 1'b0, 1'b0};
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        shadow   = 32'd0;
        rr_trc   = 1'b1;
        exp_drop = 1'b0;
        cur      = park_beat();
    endfunction

    // Expand the presented record into its full list of expected beats
    function automatic void push_record();
        int len;
        len = (int'(bus.trc_str_len) > STR_BYTES) ? STR_BYTES : int'(bus.trc_str_len);
        exp_q.push_back({T_CNT, 22'd0, bus.trc_counter, 1'b1, 1'b1});
        exp_q.push_back({T_EIP, 22'd0, bus.trc_eip, 1'b1, 1'b1});
        for (int i = 0; i < BIN_BYTES; i++)
            exp_q.push_back({T_BIN, 22'd0, 24'd0, 8'(bus.trc_bin >> (8 * i)), 1'b1, 1'b1});
        for (int i = 0; i < len; i++)
            exp_q.push_back({T_STR, 22'd0, 24'd0, 8'(bus.trc_str >> (8 * i)), 1'b1, 1'b1});
    endfunction

    function automatic logic legal_tag(input logic [7:0] t);
        return (t >= T_CNT) && (t <= T_STR);
    endfunction

    task automatic check_bus();
        check_eq("dbg_addr", 64'(bus.dbg_addr), 64'(cur.addr));
        check_eq("dbg_data", 64'(bus.dbg_data), 64'(cur.data));
        check_eq("dbg_we",   64'(bus.dbg_we),   64'(cur.we));
        check_eq("busy",     64'(bus.busy),     64'(cur.busy));
        check_eq("drop",     64'(bus.drop),     64'(exp_drop));
    endtask

    // One clock: predict and check readies, advance the model, check the bus
    task automatic step();
        logic [29:0] ca;
        @(negedge clk);
        if (!rst_n || exp_q.size() != 0) begin
            g_cpu = 1'b0;
            g_trc = 1'b0;
        end else if (bus.cpu_valid && bus.trc_valid) begin
            g_cpu = rr_trc;
            g_trc = !rr_trc;
        end else begin
            g_cpu = bus.cpu_valid;
            g_trc = bus.trc_valid;
        end
        check_eq("cpu_ready", 64'(bus.cpu_ready), 64'(g_cpu));
        check_eq("trc_ready", 64'(bus.trc_ready), 64'(g_trc));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_drop = 1'b0;
            if (g_trc) begin
                rr_trc = 1'b1;
                push_record();
            end
            if (g_cpu) begin
                rr_trc = 1'b0;
                ca = bus.cpu_addr;
                if (legal_tag(ca[29:22])) exp_q.push_back({bus.cpu_addr, bus.cpu_data, 1'b1, 1'b0});
                else                      exp_drop = 1'b1;
            end
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                if (cur.addr[29:22] == T_EIP) shadow = cur.data;
            end else begin
                cur = park_beat();
            end
        end
        #1;
        check_bus();
    endtask

    task automatic new_cpu(input logic [7:0] tag);
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = {tag, 22'($urandom)};
        bus.cpu_data  = $urandom;
    endtask

    task automatic new_trc(input logic [5:0] len);
        logic [8*BIN_BYTES-1:0] b;
        logic [8*STR_BYTES-1:0] s;
        b = '0;
        s = '0;
        for (int i = 0; i < BIN_BYTES; i++) b = {b[8*BIN_BYTES-9:0], 8'($urandom)};
        for (int i = 0; i < STR_BYTES / 4; i++) s = {s[8*STR_BYTES-33:0], 32'($urandom)};
        bus.trc_valid   = 1'b1;
        bus.trc_counter = $urandom;
        bus.trc_eip     = $urandom;
        bus.trc_bin     = b;
        bus.trc_str     = s;
        bus.trc_str_len = len;
    endtask

    task automatic wait_grant(input logic want_trc, input int limit);
        logic got;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            step();
            got = want_trc ? g_trc : g_cpu;
        end
        check_eq(want_trc ? "trc_grant_seen" : "cpu_grant_seen", 64'(got), 64'(1));
    endtask

    task automatic idle(input int n, output int nbusy);
        nbusy = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.busy === 1'b1) nbusy++;
        end
    endtask

    function automatic logic [7:0] rand_tag();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return T_CNT + 8'(r % 4);
        else       return 8'($urandom);
    endfunction

    initial begin
        int nb;
        logic [8*BIN_BYTES-1:0] b;

        rst_n           = 1'b0;
        bus.cpu_valid   = 1'b0;
        bus.cpu_addr    = 30'd0;
        bus.cpu_data    = 32'd0;
        bus.trc_valid   = 1'b0;
        bus.trc_counter = 32'd0;
        bus.trc_eip     = 32'd0;
        bus.trc_bin     = '0;
        bus.trc_str     = '0;
        bus.trc_str_len = 6'd0;
        model_reset();

        // Both requesters valid out of reset: CPU first, record next cycle
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = {T_CNT, 22'h4};
        bus.cpu_data  = 32'd7;
        new_trc(6'd4);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_eq("first_beat_cpu_addr", 64'(bus.dbg_addr), 64'({T_CNT, 22'h4}));
        new_cpu(T_STR);
        step();
        bus.trc_valid = 1'b0;
        wait_grant(1'b0, 40);
        bus.cpu_valid = 1'b0;
        idle(4, nb);

        // Single known record
        b = '0;
        for (int i = BIN_BYTES - 1; i >= 0; i--) b = {b[8*BIN_BYTES-9:0], 8'(i + 1)};
        bus.trc_valid       = 1'b1;
        bus.trc_counter     = 32'h12;
        bus.trc_eip         = 32'h0010_0000;
        bus.trc_bin         = b;
        bus.trc_str         = '0;
        bus.trc_str[23:0]   = 24'h636261;
        bus.trc_str_len     = 6'd3;
        wait_grant(1'b1, 20);
        bus.trc_valid = 1'b0;
        idle(20, nb);
        check_eq("busy_cycles_len3", 64'(nb + 1), 64'(15));
        check_eq("park_after_record", 64'(bus.dbg_data), 64'(32'h0010_0000));

        // Zero-length and clamped strings
        new_trc(6'd0);
        wait_grant(1'b1, 20);
        bus.trc_valid = 1'b0;
        idle(20, nb);
        check_eq("busy_cycles_len0", 64'(nb + 1), 64'(12));
        new_trc(6'd40);
        wait_grant(1'b1, 20);
        bus.trc_valid = 1'b0;
        idle(60, nb);
        check_eq("busy_cycles_len40", 64'(nb + 1), 64'(44));

        // Back-to-back records with trc_valid held
        new_trc(6'd5);
        wait_grant(1'b1, 20);
        new_trc(6'd7);
        wait_grant(1'b1, 60);
        bus.trc_valid = 1'b0;
        idle(30, nb);

        // Illegal tag is consumed and dropped
        new_cpu(8'h55);
        wait_grant(1'b0, 5);
        bus.cpu_valid = 1'b0;
        idle(3, nb);

        // Reset in the middle of a burst
        new_trc(6'd8);
        wait_grant(1'b1, 20);
        bus.trc_valid = 1'b0;
        idle(4, nb);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_bus();
        new_trc(6'd2);
        step();
        step();
        rst_n = 1'b1;
        wait_grant(1'b1, 5);
        bus.trc_valid = 1'b0;
        check_eq("post_reset_a0", 64'(bus.dbg_addr), 64'({T_CNT, 22'd0}));
        idle(20, nb);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            if (g_cpu) bus.cpu_valid = 1'b0;
            if (g_trc) bus.trc_valid = 1'b0;
            if (!bus.cpu_valid && $urandom_range(0, 99) < 30) new_cpu(rand_tag());
            if (!bus.trc_valid && $urandom_range(0, 99) < 8) new_trc(6'($urandom_range(0, 63)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
